// File: rtl/drive_sequencer.sv
// Per-motor drive sequencer: soft-start ramp, overcurrent filter, cooldown/retry and fault latch.
// Channels A and B are built from one generate body and share only ClearFault.
module drive_sequencer #(
    parameter int unsigned RAMP_TICKS  = 4,
    parameter int unsigned FILT_CYCLES = 3,
    parameter int unsigned COOL_TICKS  = 16,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] ReqA,
    input  logic [1:0] ReqB,
    input  logic       OverA,
    input  logic       OverB,
    input  logic       ClearFault,
    output logic [1:0] DriveA,
    output logic [1:0] DriveB,
    output logic       FaultA,
    output logic       FaultB
);

    localparam int unsigned RampW  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int unsigned FiltW  = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int unsigned CoolW  = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    localparam logic [RampW-1:0]  RampLast = RampW'(RAMP_TICKS - 1);
    localparam logic [FiltW-1:0]  FiltLast = FiltW'(FILT_CYCLES - 1);
    localparam logic [CoolW-1:0]  CoolLast = CoolW'(COOL_TICKS - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    localparam logic [1:0] StRun  = 2'd0;
    localparam logic [1:0] StCool = 2'd1;
    localparam logic [1:0] StLock = 2'd2;

    logic [1:0] req_w   [2];
    logic       over_w  [2];
    logic [1:0] drive_w [2];
    logic       fault_w [2];

    assign req_w[0]  = ReqA;
    assign req_w[1]  = ReqB;
    assign over_w[0] = OverA;
    assign over_w[1] = OverB;
    assign DriveA    = drive_w[0];
    assign DriveB    = drive_w[1];
    assign FaultA    = fault_w[0];
    assign FaultB    = fault_w[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [1:0]        lvl_q, lvl_d;
        logic [RampW-1:0]  ramp_q, ramp_d;
        logic [FiltW-1:0]  filt_q, filt_d;
        logic [CoolW-1:0]  cool_q, cool_d;
        logic [RetryW-1:0] retry_q, retry_d;
        logic              fault_q, fault_d;

        always_comb begin
            state_d = state_q;
            lvl_d   = lvl_q;
            ramp_d  = ramp_q;
            filt_d  = filt_q;
            cool_d  = cool_q;
            retry_d = retry_q;
            fault_d = fault_q;
            case (state_q)
                StRun: begin
                    retry_d = ClearFault ? '0 : retry_q;
                    // A confirmed fault wins over any ramp or request change on this edge
                    if (over_w[c] && (filt_q == FiltLast)) begin
                        lvl_d   = 2'd0;
                        ramp_d  = '0;
                        filt_d  = '0;
                        cool_d  = '0;
                        retry_d = retry_d + RetryW'(1);
                        if (retry_d == RetryMax) begin
                            state_d = StLock;
                            fault_d = 1'b1;
                        end else begin
                            state_d = StCool;
                        end
                    end else begin
                        filt_d = over_w[c] ? filt_q + FiltW'(1) : '0;
                        if (req_w[c] > lvl_q) begin
                            if (ramp_q == RampLast) begin
                                lvl_d  = lvl_q + 2'd1;
                                ramp_d = '0;
                            end else begin
                                ramp_d = ramp_q + RampW'(1);
                            end
                        end else begin
                            lvl_d  = req_w[c];
                            ramp_d = '0;
                        end
                    end
                end
                StCool: begin
                    lvl_d = 2'd0;
                    if (ClearFault) retry_d = '0;
                    if (cool_q == CoolLast) begin
                        state_d = StRun;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q + CoolW'(1);
                    end
                end
                StLock: begin
                    lvl_d = 2'd0;
                    if (ClearFault) begin
                        state_d = StRun;
                        fault_d = 1'b0;
                        retry_d = '0;
                        ramp_d  = '0;
                        filt_d  = '0;
                        cool_d  = '0;
                    end
                end
                default: begin
                    state_d = StRun;
                    lvl_d   = 2'd0;
                    ramp_d  = '0;
                    filt_d  = '0;
                    cool_d  = '0;
                    fault_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                state_q <= StRun;
                lvl_q   <= 2'd0;
                ramp_q  <= '0;
                filt_q  <= '0;
                cool_q  <= '0;
                retry_q <= '0;
                fault_q <= 1'b0;
            end else begin
                state_q <= state_d;
                lvl_q   <= lvl_d;
                ramp_q  <= ramp_d;
                filt_q  <= filt_d;
                cool_q  <= cool_d;
                retry_q <= retry_d;
                fault_q <= fault_d;
            end
        end

        assign drive_w[c] = lvl_q;
        assign fault_w[c] = fault_q;
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with default parameters (ramp 4, filter 3, cool 16, retry 3).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_drive_sequencer;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] ReqA = 2'd0;
    logic [1:0] ReqB = 2'd0;
    logic       OverA = 1'b0;
    logic       OverB = 1'b0;
    logic       ClearFault = 1'b0;
    logic [1:0] DriveA, DriveB;
    logic       FaultA, FaultB;

    int n_cmp = 0;
    int n_bad = 0;

    drive_sequencer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ReqA       (ReqA),
        .ReqB       (ReqB),
        .OverA      (OverA),
        .OverB      (OverB),
        .ClearFault (ClearFault),
        .DriveA     (DriveA),
        .DriveB     (DriveB),
        .FaultA     (FaultA),
        .FaultB     (FaultB)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        ReqA = 2'd0; ReqB = 2'd0; OverA = 1'b0; OverB = 1'b0; ClearFault = 1'b0;
        step(2);
        nRST = 1'b1;
    endtask

    // Stimulus only: one confirmed fault on A followed by a full cooldown.
    task automatic fault_a();
        OverA = 1'b1;
        step(3);
        OverA = 1'b0;
        step(16);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #3;
        n_cmp++;
        if ({DriveA, DriveB, FaultA, FaultB} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000", {DriveA, DriveB, FaultA, FaultB});
        end
        do_reset();
    endtask

    task automatic test_soft_start();
        logic [1:0] exp;
        do_reset();
        ReqA = 2'd3;
        for (int e = 1; e <= 14; e++) begin
            step(1);
            exp = (e >= 12) ? 2'd3 : 2'(e / 4);
            n_cmp++;
            if (DriveA !== exp) begin
                n_bad++;
                $display("FAIL soft_start_A edge %0d: got %0d want %0d", e, DriveA, exp);
            end
            n_cmp++;
            if (DriveB !== 2'd0) begin
                n_bad++;
                $display("FAIL soft_start_B edge %0d: got %0d want 0", e, DriveB);
            end
        end
    endtask

    task automatic test_decrease();
        logic [1:0] exp;
        ReqA = 2'd1;
        step(1);
        n_cmp++;
        if (DriveA !== 2'd1) begin
            n_bad++;
            $display("FAIL decrease: got %0d want 1", DriveA);
        end
        ReqA = 2'd2;
        for (int e = 1; e <= 4; e++) begin
            step(1);
            exp = (e < 4) ? 2'd1 : 2'd2;
            n_cmp++;
            if (DriveA !== exp) begin
                n_bad++;
                $display("FAIL reramp edge %0d: got %0d want %0d", e, DriveA, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ReqA = 2'd3;
        step(4);
        n_cmp++;
        if (DriveA !== 2'd3) begin
            n_bad++;
            $display("FAIL glitch_setup: got %0d want 3", DriveA);
        end
        for (int i = 0; i < 6; i++) begin
            OverA = pat[i];
            step(1);
            n_cmp++;
            if ({DriveA, FaultA} !== 3'b110) begin
                n_bad++;
                $display("FAIL glitch step %0d: drive %0d fault %0b want 3/0", i, DriveA, FaultA);
            end
        end
        OverA = 1'b0;
    endtask

    task automatic test_fault_retry();
        logic [1:0] exp;
        OverA = 1'b1;
        step(2);
        n_cmp++;
        if (DriveA !== 2'd3) begin
            n_bad++;
            $display("FAIL fault_early: got %0d want 3", DriveA);
        end
        step(1);
        OverA = 1'b0;
        n_cmp++;
        if (DriveA !== 2'd0) begin
            n_bad++;
            $display("FAIL fault_cut: got %0d want 0", DriveA);
        end
        for (int e = 1; e <= 16; e++) begin
            step(1);
            n_cmp++;
            if (DriveA !== 2'd0) begin
                n_bad++;
                $display("FAIL cooldown edge %0d: got %0d want 0", e, DriveA);
            end
        end
        for (int e = 1; e <= 12; e++) begin
            step(1);
            exp = 2'(e / 4);
            n_cmp++;
            if (DriveA !== exp) begin
                n_bad++;
                $display("FAIL retry_ramp edge %0d: got %0d want %0d", e, DriveA, exp);
            end
        end
        n_cmp++;
        if (FaultA !== 1'b0) begin
            n_bad++;
            $display("FAIL retry_nolatch: FaultA %0b want 0", FaultA);
        end
    endtask

    task automatic test_latch_clear();
        do_reset();
        ReqA = 2'd3;
        ReqB = 2'd2;
        fault_a();
        fault_a();
        n_cmp++;
        if (FaultA !== 1'b0) begin
            n_bad++;
            $display("FAIL latch_early: FaultA %0b want 0", FaultA);
        end
        OverA = 1'b1;
        step(3);
        OverA = 1'b0;
        n_cmp++;
        if ({DriveA, FaultA} !== 3'b001) begin
            n_bad++;
            $display("FAIL latch_enter: drive %0d fault %0b want 0/1", DriveA, FaultA);
        end
        for (int e = 1; e <= 100; e++) begin
            step(1);
            n_cmp++;
            if ({DriveA, FaultA} !== 3'b001) begin
                n_bad++;
                $display("FAIL latch_hold %0d: drive %0d fault %0b want 0/1", e, DriveA, FaultA);
            end
        end
        n_cmp++;
        if ({DriveB, FaultB} !== 3'b100) begin
            n_bad++;
            $display("FAIL latch_chan_b: drive %0d fault %0b want 2/0", DriveB, FaultB);
        end
        ClearFault = 1'b1;
        step(1);
        ClearFault = 1'b0;
        n_cmp++;
        if ({DriveA, FaultA} !== 3'b000) begin
            n_bad++;
            $display("FAIL clear: drive %0d fault %0b want 0/0", DriveA, FaultA);
        end
        step(3);
        n_cmp++;
        if (DriveA !== 2'd0) begin
            n_bad++;
            $display("FAIL clear_ramp3: got %0d want 0", DriveA);
        end
        step(1);
        n_cmp++;
        if (DriveA !== 2'd1) begin
            n_bad++;
            $display("FAIL clear_ramp4: got %0d want 1", DriveA);
        end
    endtask

    // Two faults, then ClearFault while running: the next fault must cool, not latch.
    task automatic test_clear_retry();
        do_reset();
        ReqA = 2'd3;
        fault_a();
        fault_a();
        ClearFault = 1'b1;
        step(1);
        ClearFault = 1'b0;
        OverA = 1'b1;
        step(3);
        OverA = 1'b0;
        n_cmp++;
        if ({DriveA, FaultA} !== 3'b000) begin
            n_bad++;
            $display("FAIL clear_retry: drive %0d fault %0b want 0/0", DriveA, FaultA);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ReqA = 2'd3;
        ReqB = 2'd2;
        fault_a();
        fault_a();
        fault_a();
        ReqB = 2'd3;
        step(2);
        n_cmp++;
        if ({DriveB, FaultA} !== 3'b101) begin
            n_bad++;
            $display("FAIL pre_reset: driveB %0d faultA %0b want 2/1", DriveB, FaultA);
        end
        #2;
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({DriveA, DriveB, FaultA, FaultB} !== 6'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want 000000", {DriveA, DriveB, FaultA, FaultB});
        end
        step(1);
        nRST = 1'b1;
        step(3);
        n_cmp++;
        if ({DriveA, DriveB} !== 4'b0000) begin
            n_bad++;
            $display("FAIL post_reset3: A %0d B %0d want 0/0", DriveA, DriveB);
        end
        step(1);
        n_cmp++;
        if ({DriveA, DriveB} !== 4'b0101) begin
            n_bad++;
            $display("FAIL post_reset4: A %0d B %0d want 1/1", DriveA, DriveB);
        end
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_decrease();
        test_glitch();
        test_fault_retry();
        test_latch_clear();
        test_clear_retry();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Controller between the line-following movement logic and the PWM generator.
- Takes per-motor speed requests and issues the DriveA/DriveB levels the PWM generator consumes.
- Applies a soft-start ramp on speed increases.
- Filters the per-motor overcurrent flags.
- On a confirmed overcurrent, forces a cooldown and retry, and after repeated faults latches the motor off until cleared.
- Motors A and B are sequenced independently by identical per-channel logic.

Parameters:
RAMP_TICKS, 4, cycles per one-level speed increase (>=1)
FILT_CYCLES, 3, consecutive Over=1 samples that confirm a fault (>=1)
COOL_TICKS, 16, cycles a channel is held at level 0 after a fault (>=1)
MAX_RETRY, 3, faults before the channel latches (>=1)

Ports:
CLK  input  1  system clock; all state updates on the rising edge
nRST  input  1  asynchronous active-low reset
ReqA  input  2  requested speed level for motor A (0=off, 3=max)
ReqB  input  2  requested speed level for motor B
OverA  input  1  motor A overcurrent flag, already synchronous to CLK
OverB  input  1  motor B overcurrent flag, already synchronous to CLK
ClearFault  input  1  single-cycle pulse that clears latched faults and retry counts on both channels
DriveA  output  2  registered speed level to the PWM generator, motor A
DriveB  output  2  registered speed level to the PWM generator, motor B
FaultA  output  1  motor A latched-fault indicator
FaultB  output  1  motor B latched-fault indicator

Behaviour:
Per-channel state. The description uses A; B is identical.
- State register: RUN, COOL or LOCK.
- Registers: level lvl (drives DriveA), ramp counter, filter counter, cool counter, retry count.
- Counter widths are derived from their parameters with $clog2 and must not overflow.

Reset (nRST=0, asynchronous):
- State = RUN.
- All counters = 0.
- DriveA = DriveB = 0.
- FaultA = FaultB = 0.

RUN:
- If ReqA > lvl: the ramp counter increments each cycle. On the edge where it equals RAMP_TICKS-1, lvl increments by 1 and the counter returns to 0.
- If ReqA <= lvl: lvl <= ReqA immediately, so a decrease appears one edge after the request. The ramp counter resets to 0.
- A request that rises again mid-ramp continues from the current lvl.
- Filter counter:
  - Increments while OverA=1.
  - Clears to 0 on any cycle with OverA=0.
  - Fault event occurs on the edge where OverA=1 and the counter equals FILT_CYCLES-1.
- On a fault event:
  - lvl <= 0 on that edge; ramp and filter counters <= 0; retry count increments.
  - If the new retry count equals MAX_RETRY, go to LOCK.
  - Otherwise go to COOL with the cool counter = 0.
- A fault event overrides ramp and request changes on the same edge.

COOL:
- lvl held at 0; OverA and ReqA are ignored.
- The cool counter increments each cycle. On the edge where it equals COOL_TICKS-1, go to RUN with lvl = 0.
- Ramping restarts from 0.

LOCK:
- lvl held at 0; FaultA = 1; OverA and ReqA are ignored.
- ClearFault=1 on an edge: go to RUN, FaultA <= 0, retry count <= 0, all counters <= 0.

ClearFault in RUN or COOL:
- Clears the retry count only.
- COOL timing is unaffected.

Retry count:
- Never decays by itself.
- Cleared only by ClearFault or reset.

Channel independence:
- A fault, cooldown or lock on one channel has no effect on the other.
- ClearFault acts on both channels in the same cycle.

Outputs:
- All outputs are registered; no combinational path from inputs to outputs.
- Latency from a request or flag change to an output change is ≥1 edge.

Reset mid-operation:
- Any state returns to RUN/0 immediately and asynchronously, including LOCK.

Test Plan:
1. Soft-start: reset, then ReqA=3 held, OverA=0 -> DriveA goes 1 after the 4th edge, 2 after the 8th, 3 after the 12th, then stays 3; DriveB stays 0.
2. Immediate decrease: DriveA=3, then ReqA=1 -> DriveA=1 on the next edge. Then ReqA=2 -> DriveA=2 four edges later.
3. Glitch filter: DriveA=3, OverA pulses high for 2 cycles, low for 1, high for 2 -> no fault; DriveA stays 3, FaultA=0.
4. Fault and retry:
   - Stimulus: DriveA=3, ReqA=3, OverA high for 3 edges.
   - DriveA=0 on the 3rd edge.
   - Held at 0 for 16 edges.
   - Then ramps back: 1 after 4 more edges, 3 after 12 more edges.
5. Latch and clear:
   - Stimulus: three confirmed faults on A, each separated by a full cooldown.
   - After the third: FaultA=1, DriveA=0, and DriveA stays 0 for 100 cycles with ReqA=3.
   - ClearFault pulse -> FaultA=0 next edge, ramp resumes.
   - Channel B is unaffected throughout, ramping normally with ReqB=2.
6. Async reset in LOCK and mid-ramp: assert nRST=0 between clock edges -> DriveA, DriveB, FaultA, FaultB all 0 before the next edge. After release, the ramp begins from 0.
